// File: rtl/async_sram_ctrl.sv
// Controller for a single-port asynchronous SRAM behind a valid/ready request/response interface.
// Every SRAM-side output is a flop, so the strobes are glitch-free and no input reaches a pad combinationally.
`timescale 1ns/1ps

// state      | meaning
// IDLE       | ready for a request, strobes low, pad driver off
// RD_SETUP   | address settles, pad driver off before oe rises
// RD_ACCESS  | cs/oe high, down-counter runs to the data sample point
// RD_RESP    | read data held on rsp_rdata_o until accepted
// WR_SETUP   | address and data settle with the pad driver on
// WR_PULSE   | cs/we high, down-counter sets the pulse width
// WR_HOLD    | strobes low, address/data/driver held one more cycle
module async_sram_ctrl #(
    parameter int ADDR_WIDTH         = 8,
    parameter int DATA_WIDTH         = 8,
    parameter int READ_WAIT_CYCLES   = 2,
    parameter int WRITE_PULSE_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic                  sram_oe_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_data_o,
    output logic                  sram_data_oe_o,
    input  logic [DATA_WIDTH-1:0] sram_data_i
);

    localparam int MAX_WAIT = (READ_WAIT_CYCLES > WRITE_PULSE_CYCLES) ?
                              READ_WAIT_CYCLES : WRITE_PULSE_CYCLES;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        RD_RESP,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cs_d, we_d, oe_d, data_oe_d, rsp_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d, rdata_d;

    assign req_ready_o = (state_q == IDLE);

    // Strobe values are computed for the next state and registered together with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        data_oe_d   = sram_data_oe_o;
        rsp_valid_d = rsp_valid_o;
        addr_d      = sram_addr_o;
        wdata_d     = sram_data_o;
        rdata_d     = rsp_rdata_o;
        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    if (req_we_i) begin
                        wdata_d   = req_wdata_i;
                        data_oe_d = 1'b1;
                        state_d   = WR_SETUP;
                    end else begin
                        state_d = RD_SETUP;
                    end
                end
            end
            RD_SETUP: begin
                cs_d    = 1'b1;
                oe_d    = 1'b1;
                cnt_d   = RD_LOAD;
                state_d = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d     = sram_data_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RD_RESP;
                end else begin
                    cs_d  = 1'b1;
                    oe_d  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR_SETUP: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                cnt_d   = WR_LOAD;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cs_d  = 1'b1;
                    we_d  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                data_oe_d   = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sram_cs_o      <= 1'b0;
            sram_we_o      <= 1'b0;
            sram_oe_o      <= 1'b0;
            sram_data_oe_o <= 1'b0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_rdata_o    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sram_cs_o      <= cs_d;
            sram_we_o      <= we_d;
            sram_oe_o      <= oe_d;
            sram_data_oe_o <= data_oe_d;
            sram_addr_o    <= addr_d;
            sram_data_o    <= wdata_d;
            rsp_valid_o    <= rsp_valid_d;
            rsp_rdata_o    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Scoreboard bench for async_sram_ctrl: default instance for directed/random traffic against an
// SRAM pin model, plus a READ_WAIT_CYCLES=3 / WRITE_PULSE_CYCLES=2 instance for timing.
`timescale 1ns/1ps

module tb_async_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_we, req_ready;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       sram_cs, sram_we, sram_oe, sram_data_oe;
    logic [7:0] sram_addr, sram_wdata, sram_rdata;

    logic       b_req_valid, b_req_we, b_req_ready;
    logic [7:0] b_req_addr, b_req_wdata;
    logic       b_rsp_valid, b_rsp_ready;
    logic [7:0] b_rsp_rdata;
    logic       b_cs, b_we, b_oe, b_data_oe;
    logic [7:0] b_addr, b_wdata, b_rdata;

    logic [7:0] sram_mem [256];
    logic [7:0] b_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q [$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   we_total = 0;
    logic rand_rdy = 1'b0;
    logic prev_cs = 1'b0, prev_oe = 1'b0, prev_doe = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    always #5 clk = ~clk;

    async_sram_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_oe_o(sram_oe),
        .sram_addr_o(sram_addr), .sram_data_o(sram_wdata),
        .sram_data_oe_o(sram_data_oe), .sram_data_i(sram_rdata)
    );

    async_sram_ctrl #(.READ_WAIT_CYCLES(3), .WRITE_PULSE_CYCLES(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .sram_cs_o(b_cs), .sram_we_o(b_we), .sram_oe_o(b_oe),
        .sram_addr_o(b_addr), .sram_data_o(b_wdata),
        .sram_data_oe_o(b_data_oe), .sram_data_i(b_rdata)
    );

    // SRAM pin models: a write needs cs, we and the pad driver; reads return junk unless cs & oe.
    always @(posedge clk) begin
        if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_data_oe ? sram_wdata : 8'h00;
        if (b_cs && b_we)       b_mem[b_addr]       <= b_data_oe ? b_wdata : 8'h00;
    end
    assign sram_rdata = (sram_cs && sram_oe) ? sram_mem[sram_addr] : 8'hEE;
    assign b_rdata    = (b_cs && b_oe) ? b_mem[b_addr] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin-level invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("we_and_oe", 32'(sram_we & sram_oe), 0);
            chk("doe_and_oe", 32'(sram_data_oe & sram_oe), 0);
            chk("b_we_and_oe", 32'(b_we & b_oe), 0);
            if (prev_cs && sram_cs) chk("addr_stable_cs", 32'(sram_addr), 32'(prev_addr));
            if (sram_oe && !prev_oe) chk("turnaround", 32'(prev_doe), 0);
            if (sram_we) we_total++;
        end
        prev_cs   <= sram_cs;
        prev_oe   <= sram_oe;
        prev_doe  <= sram_data_oe;
        prev_addr <= sram_addr;
    end

    // Response side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_spurious", 1, 0);
            else chk("rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return req_ready;
            1:       return rsp_valid;
            2:       return b_req_ready;
            default: return b_rsp_valid;
        endcase
    endfunction

    // Called just after a handshake edge; returns the cycle number (1 = first cycle after it).
    task automatic wait_sig(input int sel, output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!sig(sel) && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] d);
        int  n = 0;
        logic ok = 1'b1;
        @(posedge clk);
        #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (++n > 100) begin
                chk("req_timeout", 0, 1);
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        if (ok) begin
            if (we) ref_mem[a] = d;
            else exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic b_read(input logic [7:0] a, input logic [7:0] exp);
        int n = 0;
        int cyc;
        @(posedge clk);
        #1;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = a;
        @(negedge clk);
        while (!b_req_ready && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        wait_sig(3, cyc);
        chk("b_rd_valid_cycle", cyc, 5);
        chk("b_rd_data", 32'(b_rsp_rdata), 32'(exp));
    endtask

    initial begin
        int cyc, w0, k, n;
        int hs [2];
        logic [7:0] held;

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
        b_rsp_ready = 1'b1;
        hs[0] = 0; hs[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_strobes", 32'({sram_cs, sram_we, sram_oe, sram_data_oe}), 0);
        chk("rst_addr_data", 32'({sram_addr, sram_wdata}), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
        rst_n = 1'b1;

        // Write 0xA5 to 0x3C, then read it back.
        w0 = we_total;
        do_req(1'b1, 8'h3C, 8'hA5);
        wait_sig(0, cyc);
        chk("wr_ready_cycle", cyc, 4);
        chk("we_pulse_len", we_total - w0, 1);
        do_req(1'b0, 8'h3C, 8'h00);
        wait_sig(1, cyc);
        chk("rd_valid_cycle", cyc, 4);
        chk("rd_data", 32'(rsp_rdata), 'hA5);

        // Response back-pressure for 5 cycles.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h3C, 8'h00);
        wait_sig(1, cyc);
        held = rsp_rdata;
        chk("bp_valid_cycle", cyc, 4);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid_held", 32'(rsp_valid), 1);
            chk("bp_data_held", 32'(rsp_rdata), 32'(held));
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_after", 32'({req_ready, rsp_valid}), 'b10);

        // Reset in the middle of the write pulse.
        do_req(1'b1, 8'h77, 8'h99);
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_high", 32'(sram_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({sram_cs, sram_we, sram_data_oe}), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 0);
        end

        // Fill every address, then random traffic.
        for (int a = 0; a < 256; a++) do_req(1'b1, 8'(a), 8'($urandom));
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++)
            do_req(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);

        // Longer timing: back-to-back writes then reads on the second instance.
        @(posedge clk);
        #1;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 8'hFF; b_req_wdata = 8'h5A;
        k = 0;
        cyc = 0;
        while (k < 2 && cyc < 40) begin
            @(negedge clk);
            if (b_req_ready) begin
                hs[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (k == 1) begin
                b_req_addr = 8'h00; b_req_wdata = 8'hC3;
            end
            if (k == 2) b_req_valid = 1'b0;
        end
        chk("b_wr_count", k, 2);
        chk("b_wr_period", hs[1] - hs[0], 5);
        b_read(8'hFF, 8'h5A);
        b_read(8'h00, 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
